// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Sequencer state for the bit-serial subtractor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int unsigned SUB_DEFAULT_W = 8;

endpackage : serial_arith_pkg

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated/propagated by this bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : fs_cell

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor, LSB first, one fs_cell evaluation per cycle.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_sub
    import serial_arith_pkg::*;
#(
    parameter int unsigned W = SUB_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    sub_state_t    r_state;
    sub_state_t    w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_diff;
    logic          r_borrow;
    logic          r_bout;
    logic [CW-1:0] r_cnt;
    logic          w_d;
    logic          w_nb;
    logic          w_last;
    logic          w_accept;
`ifdef SERIAL_SUB_OVF_EN
    logic          r_ovf;
`endif

    fs_cell u_fs_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_nb)
    );

    assign w_last   = (r_cnt == CW'(W - 1));
    assign w_accept = (r_state != RUN) && start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: RUN lasts exactly W cycles, DONE exactly one
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, per-bit shift and final borrow latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_diff   <= {w_d, r_diff[W-1:1]};
            r_a      <= {1'b0, r_a[W-1:1]};
            r_b      <= {1'b0, r_b[W-1:1]};
            r_borrow <= w_nb;
            if (w_last) begin
                r_bout <= w_nb;
`ifdef SERIAL_SUB_OVF_EN
                // Borrow into the MSB differs from borrow out of it
                r_ovf  <= r_borrow ^ w_nb;
`endif
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (W=8).
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_sub #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: checks latency, busy length, result and pulse width
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ediff, input logic ebout,
                          input logic eovf);
        int n;
        int nbusy;
        start = 1'b1; a = ia; b = ib; bin = ibin;
        step();
        start = 1'b0; a = ~ia; b = ~ib; bin = ~ibin;
        n = 0; nbusy = 0;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(ediff));
        check({tag, "_bout"}, 32'(bout), 32'(ebout));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) check({tag, "_eovf_x"}, 32'(eovf), 32'd0);
`endif
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold_diff"}, 32'(diff), 32'(ediff));
    endtask

    initial begin
        int n;
        int t_first;
        int t_second;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        step();

        run_op("op35m12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
        run_op("op12m35", 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0);
        run_op("op00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("op10m0F_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        run_op("op00m00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        run_op("ovf80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("ovf7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("ovf05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

        // Starts during RUN must be ignored
        start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        step();
        n = 0;
        while (!done && n < 20) begin
            start = (n == 2 || n == 5);
            a = 8'hFF; b = 8'h01; bin = 1'b1;
            step();
            n++;
        end
        start = 1'b0;
        check("ign_latency", 32'(n), 32'd8);
        check("ign_diff", 32'(diff), 32'h23);
        check("ign_bout", 32'(bout), 32'd0);
        step();
        check("ign_idle_busy", 32'(busy), 32'd0);

        // Start held high: back-to-back operations every W+1 cycles
        start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        step();
        n = 0; t_first = -1; t_second = -1;
        while (t_second < 0 && n < 40) begin
            if (done) begin
                if (t_first < 0) begin
                    t_first = n;
                    check("b2b_first_diff", 32'(diff), 32'h23);
                    a = 8'h12; b = 8'h35;
                end else begin
                    t_second = n;
                    check("b2b_second_diff", 32'(diff), 32'hDD);
                    check("b2b_second_bout", 32'(bout), 32'd1);
                end
            end
            step();
            n++;
        end
        start = 1'b0;
        check("b2b_first_time", 32'(t_first), 32'd8);
        check("b2b_period", 32'(t_second - t_first), 32'd9);
        step();
        step();

        // Reset during RUN discards the partial result
        start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) n++;
            step();
        end
        check("mid_rst_no_done", 32'(n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_sub
